imm_gen_pipe: RTL and testbench

Parametrised, elastic successor to the single-stage immediate generator. Decodes the full 32-bit instruction and selects the immediate format from the opcode itself; format strobes are not supplied by the control unit. Produces a sign- or zero-extended XLEN-bit immediate plus a format tag through a configurable-depth valid/ready pipeline. Flush replaces the old nop/flag bubble mechanism. Sits between instruction fetch/decode and the ALU operand mux.

---
 rtl/imm_gen_pkg.sv | 40 ++++
 rtl/imm_gen_decode.sv | 30 +++
 rtl/imm_gen_pipe.sv | 83 ++++++++
 tb/tb_imm_gen_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, format tags and the opcode-to-format map for the
// immediate generator pipeline.
package imm_gen_pkg;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6,
      FMT_RSVD = 3'd7
   } fmt_e;

   // SYSTEM only carries an immediate for the CSR*I forms (funct3[2] set).
   function automatic fmt_e fmt_of(input logic [31:0] inst);
      case (inst[6:0])
         OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: return FMT_I;
         OPC_STORE:                                  return FMT_S;
         OPC_BRANCH:                                 return FMT_B;
         OPC_LUI, OPC_AUIPC:                         return FMT_U;
         OPC_JAL:                                    return FMT_J;
         OPC_SYSTEM:                                 return inst[14] ? FMT_Z : FMT_NONE;
         default:                                    return FMT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational immediate decode: format from the opcode, immediate assembled
// from the instruction fields and extended to XLEN.
module imm_gen_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [2:0]      fmt,
   output logic [XLEN-1:0] imm
);

   fmt_e f;

   always_comb begin
      f   = fmt_of(inst);
      fmt = f;
      imm = '0;
      case (f)
         FMT_I: imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
         FMT_S: imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
         FMT_B: imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U: imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
         FMT_J: imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         FMT_Z: imm = {{(XLEN-5){1'b0}}, inst[19:15]};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Elastic STAGES-deep valid/ready pipeline carrying the decoded immediate and
// format tag from instruction acceptance to the ALU operand mux.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     inst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt
);

   logic [2:0]      dec_fmt;
   logic [XLEN-1:0] dec_imm;

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] src_v;
   logic [XLEN-1:0]   imm_q   [STAGES];
   logic [2:0]        fmt_q   [STAGES];
   logic [XLEN-1:0]   src_imm [STAGES];
   logic [2:0]        src_fmt [STAGES];

   imm_gen_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .inst (inst),
      .fmt  (dec_fmt),
      .imm  (dec_imm)
   );

   assign src_v[0]   = in_valid;
   assign src_imm[0] = dec_imm;
   assign src_fmt[0] = dec_fmt;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Ripple "stage k+1 will load" unrolled: stage k may advance when the
      // consumer drains or any stage from k to the tail has a hole.
      localparam logic [STAGES-1:0] LO_MASK = STAGES'((1 << k) - 1);
      assign adv[k] = out_ready | ~&(vld | LO_MASK);

      if (k > 0) begin : g_link
         assign src_v[k]   = vld[k-1];
         assign src_imm[k] = imm_q[k-1];
         assign src_fmt[k] = fmt_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            imm_q[k] <= '0;
            fmt_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (flush)
               vld[k] <= 1'b0;
            else if (adv[k])
               vld[k] <= src_v[k];
            if (adv[k] && src_v[k]) begin
               imm_q[k] <= src_imm[k];
               fmt_q[k] <= src_fmt[k];
            end
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = vld[STAGES-1];
   assign imm       = imm_q[STAGES-1];
   assign fmt       = fmt_q[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: three pipeline configurations driven in lockstep and
// checked against a transaction-level reference with per-entry arrival times.
module tb_imm_gen_pipe;

   localparam int N   = 3;
   localparam int DEP = 32;
   localparam int STG [N] = '{1, 2, 3};
   localparam int XL  [N] = '{32, 64, 32};

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic        in_valid, flush, out_ready;

   logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
   logic [31:0] imm_a, imm_c;
   logic [63:0] imm_b;
   logic [2:0]  fmt_a, fmt_b, fmt_c;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_a (
      .clk(clk), .rst(rst), .inst(inst), .in_valid(in_valid), .in_ready(ir_a),
      .flush(flush), .out_valid(ov_a), .out_ready(out_ready), .imm(imm_a), .fmt(fmt_a));
   imm_gen_pipe #(.XLEN(64), .STAGES(2)) u_b (
      .clk(clk), .rst(rst), .inst(inst), .in_valid(in_valid), .in_ready(ir_b),
      .flush(flush), .out_valid(ov_b), .out_ready(out_ready), .imm(imm_b), .fmt(fmt_b));
   imm_gen_pipe #(.XLEN(32), .STAGES(3)) u_c (
      .clk(clk), .rst(rst), .inst(inst), .in_valid(in_valid), .in_ready(ir_c),
      .flush(flush), .out_valid(ov_c), .out_ready(out_ready), .imm(imm_c), .fmt(fmt_c));

   logic        o_v   [N];
   logic        o_ir  [N];
   logic [63:0] o_imm [N];
   logic [2:0]  o_fmt [N];
   assign o_v[0] = ov_a;  assign o_ir[0] = ir_a;  assign o_imm[0] = {32'b0, imm_a}; assign o_fmt[0] = fmt_a;
   assign o_v[1] = ov_b;  assign o_ir[1] = ir_b;  assign o_imm[1] = imm_b;          assign o_fmt[1] = fmt_b;
   assign o_v[2] = ov_c;  assign o_ir[2] = ir_c;  assign o_imm[2] = {32'b0, imm_c}; assign o_fmt[2] = fmt_c;

   int checks, failures, cyc;

   logic [63:0] m_imm [N][DEP];
   int          m_fmt [N][DEP];
   int          m_acc [N][DEP];
   int          hd [N], tl [N], last_drn [N];

   logic [31:0] tbl_inst [8] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h0010006F,
                                 32'h123452B7, 32'h800002B7, 32'h340FD073, 32'h002081B3};
   logic [63:0] tbl_imm  [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                 64'h0000000000000800, 64'h0000000012345000, 64'hFFFFFFFF80000000,
                                 64'h000000000000001F, 64'h0000000000000000};
   int          tbl_fmt  [8] = '{1, 2, 3, 5, 4, 4, 6, 0};
   localparam logic [63:0] M32 = 64'h00000000FFFFFFFF;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int ref_fmt(input logic [31:0] i);
      case (i[6:0])
         7'h03, 7'h13, 7'h1B, 7'h67: return 1;
         7'h23:                      return 2;
         7'h63:                      return 3;
         7'h37, 7'h17:               return 4;
         7'h6F:                      return 5;
         7'h73:                      return i[14] ? 6 : 0;
         default:                    return 0;
      endcase
   endfunction

   function automatic logic [63:0] ref_imm(input logic [31:0] i, input int xlen);
      longint s, v;
      s = longint'(signed'(i));
      case (ref_fmt(i))
         1: v = s >>> 20;
         2: v = ((s >>> 25) << 5) | longint'(i[11:7]);
         3: v = ((s >>> 31) << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5)
                | (longint'(i[11:8]) << 1);
         4: v = (s >>> 12) << 12;
         5: v = ((s >>> 31) << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11)
                | (longint'(i[30:21]) << 1);
         6: v = longint'(i[19:15]);
         default: v = 0;
      endcase
      if (xlen == 32) v = v & 64'h00000000FFFFFFFF;
      return 64'(v);
   endfunction

   function automatic logic [31:0] gen_inst();
      logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h00};
      int unsigned pick;
      logic [6:0]  op;
      pick = $urandom_range(0, 11);
      op   = (pick == 11) ? 7'($urandom) : ops[pick];
      return {25'($urandom), op};
   endfunction

   // Entry visible at max(accept + STAGES, previous drain + 1); pipe holds at most STAGES.
   task automatic tick();
      bit          acc [N];
      bit          drn [N];
      logic [63:0] nimm [N];
      int          nfmt [N];
      int          c0;
      #1;
      c0 = cyc;
      for (int k = 0; k < N; k++) begin
         int   cnt, ready_at, slot;
         logic vis, eir;
         cnt  = tl[k] - hd[k];
         slot = hd[k] % DEP;
         vis  = 1'b0;
         if (cnt > 0) begin
            ready_at = m_acc[k][slot] + STG[k];
            if (last_drn[k] + 1 > ready_at) ready_at = last_drn[k] + 1;
            vis = (c0 >= ready_at);
         end
         check_val($sformatf("out_valid[%0d]", k), 64'(o_v[k]), 64'(vis));
         if (vis) begin
            check_val($sformatf("imm[%0d]", k), o_imm[k], m_imm[k][slot]);
            check_val($sformatf("fmt[%0d]", k), 64'(o_fmt[k]), 64'(m_fmt[k][slot]));
         end
         eir = (cnt < STG[k]) || out_ready;
         check_val($sformatf("in_ready[%0d]", k), 64'(o_ir[k]), 64'(eir));
         acc[k]  = in_valid && eir && !flush;
         drn[k]  = vis && out_ready;
         nimm[k] = ref_imm(inst, XL[k]);
         nfmt[k] = ref_fmt(inst);
      end
      @(posedge clk);
      cyc++;
      for (int k = 0; k < N; k++) begin
         if (flush) begin
            hd[k] = tl[k];
         end else begin
            if (drn[k]) begin
               last_drn[k] = c0;
               hd[k]++;
            end
            if (acc[k]) begin
               m_imm[k][tl[k] % DEP] = nimm[k];
               m_fmt[k][tl[k] % DEP] = nfmt[k];
               m_acc[k][tl[k] % DEP] = c0;
               tl[k]++;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] held;
      checks = 0; failures = 0; cyc = 0;
      rst = 1'b1; inst = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      for (int k = 0; k < N; k++) begin
         hd[k] = 0; tl[k] = 0; last_drn[k] = -10;
      end
      #1;
      for (int k = 0; k < N; k++) begin
         check_val($sformatf("rst_ov[%0d]", k), 64'(o_v[k]), 64'd0);
         check_val($sformatf("rst_imm[%0d]", k), o_imm[k], 64'd0);
         check_val($sformatf("rst_fmt[%0d]", k), 64'(o_fmt[k]), 64'd0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Known encodings back to back; each configuration shows entry i after STAGES cycles.
      for (int i = 0; i < 10; i++) begin
         inst      = (i < 8) ? tbl_inst[i] : 32'h0;
         in_valid  = (i < 8);
         out_ready = 1'b1;
         tick();
         if (i < 8) begin
            check_val("dir_imm_a", o_imm[0], tbl_imm[i] & M32);
            check_val("dir_fmt_a", 64'(o_fmt[0]), 64'(tbl_fmt[i]));
         end
         if (i >= 1 && i <= 8) begin
            check_val("dir_imm_b", o_imm[1], tbl_imm[i-1]);
            check_val("dir_fmt_b", 64'(o_fmt[1]), 64'(tbl_fmt[i-1]));
         end
         if (i >= 2) begin
            check_val("dir_imm_c", o_imm[2], tbl_imm[i-2] & M32);
            check_val("dir_fmt_c", 64'(o_fmt[2]), 64'(tbl_fmt[i-2]));
         end
      end

      // Backpressure: fill while stalled, outputs must hold, then drain in order.
      flush = 1'b1; in_valid = 1'b0; tick(); flush = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1;
      held = '0;
      for (int i = 0; i < 4; i++) begin
         inst = gen_inst();
         tick();
         if (i == 1) held = o_imm[1];
      end
      check_val("stall_in_ready_b", 64'(o_ir[1]), 64'd0);
      check_val("stall_out_valid_b", 64'(o_v[1]), 64'd1);
      check_val("stall_hold_b", o_imm[1], held);
      out_ready = 1'b1; in_valid = 1'b0;
      repeat (5) tick();

      // Flush with a same-cycle input, then exact STAGES latency for the next one.
      for (int i = 0; i < 3; i++) begin
         inst = gen_inst(); in_valid = 1'b1; tick();
      end
      flush = 1'b1; inst = tbl_inst[0]; in_valid = 1'b1;
      tick();
      flush = 1'b0;
      check_val("flush_ov_c", 64'(o_v[2]), 64'd0);
      check_val("flush_ov_a", 64'(o_v[0]), 64'd0);
      inst = tbl_inst[6]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_val("flush_lat1_c", 64'(o_v[2]), 64'd0);
      tick();
      check_val("flush_lat2_c", 64'(o_v[2]), 64'd0);
      tick();
      check_val("flush_lat3_c", 64'(o_v[2]), 64'd1);
      check_val("flush_imm_c", o_imm[2], 64'd31);
      check_val("flush_fmt_c", 64'(o_fmt[2]), 64'd6);
      repeat (2) tick();

      // Asynchronous reset between edges with entries in flight.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inst = gen_inst(); tick();
      end
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < N; k++) begin
         check_val($sformatf("arst_ov[%0d]", k), 64'(o_v[k]), 64'd0);
         check_val($sformatf("arst_imm[%0d]", k), o_imm[k], 64'd0);
         check_val($sformatf("arst_fmt[%0d]", k), 64'(o_fmt[k]), 64'd0);
         hd[k] = tl[k];
      end
      @(posedge clk); cyc++;
      @(negedge clk);
      rst = 1'b0;
      inst = tbl_inst[4]; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check_val("post_rst_ov_a", 64'(o_v[0]), 64'd1);
      check_val("post_rst_imm_a", o_imm[0], 64'h12345000);
      check_val("post_rst_fmt_a", 64'(o_fmt[0]), 64'd4);
      tick();

      // Randomised traffic with bursts of backpressure and occasional flush.
      for (int i = 0; i < 600; i++) begin
         inst      = gen_inst();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         tick();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
